fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared processor types and widths for the fetch stage
package fetch_stage_pkg;

    localparam int PC_WIDTH   = 12;
    localparam int INST_WIDTH = 19;
    localparam int NOP_ENC    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with write-enable and flush
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int PC_W   = PC_WIDTH,
    parameter int INST_W = INST_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              flush_i,
    input  logic [PC_W-1:0]   pc_plus1_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [PC_W-1:0]   pc_plus1_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_o
);

    logic [PC_W-1:0]   pc_plus1_q;
    logic [INST_W-1:0] inst_q;
    logic              valid_q;

    // Flush outranks write so a redirect always kills the wrong-path fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_plus1_q <= '0;
            inst_q     <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            inst_q     <= INST_W'(NOP_ENC);
            valid_q    <= 1'b0;
        end else if (we_i) begin
            pc_plus1_q <= pc_plus1_i;
            inst_q     <= inst_i;
            valid_q    <= 1'b1;
        end
    end

    assign pc_plus1_o = pc_plus1_q;
    assign inst_o     = inst_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register, next-PC mux and IDLE/RUN/HALTED control
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = PC_WIDTH,
    parameter int              INST_W   = INST_WIDTH,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              ret,
    input  logic [PC_W-1:0]   ret_target,
    input  logic              jmp,
    input  logic [PC_W-1:0]   jmp_target,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              imem_halt,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   if_id_pc_plus1,
    output logic [INST_W-1:0] if_id_inst,
    output logic              if_id_valid,
    output logic              halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] redir_target;
    logic            redirect;
    logic            ifid_we;
    logic            ifid_flush;

    assign pc_plus1 = pc_q + PC_W'(1);
    assign redirect = br_taken | ret | jmp;

    always_comb begin
        redir_target = jmp_target;
        if (br_taken)  redir_target = br_target;
        else if (ret)  redir_target = ret_target;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pc_d = RESET_PC;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d       = redir_target;
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    ifid_we = 1'b1;
                    // A halt is latched into IF/ID but the PC stays on it.
                    if (imem_halt) state_d = ST_HALTED;
                    else           pc_d    = pc_plus1;
                end
            end
            ST_HALTED: begin
                ifid_flush = 1'b1;
                if (br_taken) begin
                    pc_d    = br_target;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    if_id_reg #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .we_i       (ifid_we),
        .flush_i    (ifid_flush),
        .pc_plus1_i (pc_plus1),
        .inst_i     (imem_inst),
        .pc_plus1_o (if_id_pc_plus1),
        .inst_o     (if_id_inst),
        .valid_o    (if_id_valid)
    );

    assign pc     = pc_q;
    assign halted = halted_q;

endmodule
